// File: rtl/mem_port_arbiter_pkg.sv
// ------------------------------------------------------------------
// mem_port_arbiter_pkg : shared encodings for the memory port arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mem_port_arbiter_pkg;

  localparam logic [1:0] W_NONE = 2'd0;
  localparam logic [1:0] W_BYTE = 2'd1;
  localparam logic [1:0] W_HALF = 2'd2;
  localparam logic [1:0] W_WORD = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } own_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ------------------------------------------------------------------
// mem_port_arbiter_if : fetch, LSU and memory-side signals of the arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        ls_req;
  logic [31:0] ls_addr;
  logic        ls_we;
  logic [1:0]  ls_width;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        ls_err;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, ls_req, ls_addr, ls_we, ls_width, ls_wdata,
           mem_ack, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err,
           ls_gnt, ls_rvalid, ls_rdata, ls_err,
           mem_req, mem_addr, mem_we, mem_be, mem_wdata
  );

  modport master (
    output if_req, if_addr, ls_req, ls_addr, ls_we, ls_width, ls_wdata,
           mem_ack, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err,
           ls_gnt, ls_rvalid, ls_rdata, ls_err,
           mem_req, mem_addr, mem_we, mem_be, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_lane_align.sv
// ------------------------------------------------------------------
// mem_lane_align : byte enables, store-lane replication, load right-align
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]  i_width,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  // o_misalign also covers the illegal zero width
  always_comb begin
    o_be       = 4'b0000;
    o_wdata    = i_wdata;
    o_misalign = 1'b0;
    case (i_width)
      W_NONE: o_misalign = 1'b1;
      W_BYTE: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      W_HALF: begin
        o_be       = 4'b0011 << i_off;
        o_wdata    = {2{i_wdata[15:0]}};
        o_misalign = i_off[0];
      end
      W_WORD: begin
        o_be       = 4'b1111;
        o_misalign = |i_off;
      end
    endcase
  end

  assign o_rdata = i_rdata >> {i_off, 3'b000};

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ------------------------------------------------------------------
// mem_port_arbiter : shares one variable-latency memory between IF and LSU
// Optional: define MEM_ARB_RR_EN for round-robin instead of LSU priority
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [TO_W-1:0] c_timeout_lim = TO_W'(TIMEOUT);

  state_t          r_state;
  state_t          w_state_nxt;
  own_t            r_owner;
  logic [TO_W-1:0] r_cnt;
  logic [31:0]     r_addr;
  logic            r_we;
  logic [3:0]      r_be;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic            r_err;

  logic            w_idle;
  logic            w_pick_ls;
  logic            w_gnt_ls;
  logic            w_gnt_if;
  logic            w_ack;
  logic            w_expire;
  logic [TO_W-1:0] w_cnt_inc;
  logic            w_if_rvalid;
  logic            w_ls_rvalid;
  logic [1:0]      w_off;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata_rep;
  logic [31:0]     w_rdata_sh;
  logic            w_misalign;
  logic            w_unused;

  assign w_unused = ^bus.if_addr[1:0];

`ifdef MEM_ARB_RR_EN
  logic r_prio_ls;

  // On contention the requester that did not win last time goes first
  assign w_pick_ls = bus.ls_req & (~bus.if_req | r_prio_ls);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio_ls <= 1'b1;
    end else if (w_gnt_ls | w_gnt_if) begin
      r_prio_ls <= w_gnt_if;
    end
  end
`else
  assign w_pick_ls = bus.ls_req;
`endif

  assign w_idle   = (r_state == IDLE) & ~rst;
  assign w_gnt_ls = w_idle & w_pick_ls;
  assign w_gnt_if = w_idle & bus.if_req & ~w_pick_ls;

  assign w_ack     = bus.mem_ack & (r_state == ACCESS);
  assign w_cnt_inc = r_cnt + TO_W'(1);
  assign w_expire  = (w_cnt_inc == c_timeout_lim);

  // Live LSU offset while sampling, captured offset while aligning read data
  assign w_off = (r_state == IDLE) ? bus.ls_addr[1:0] : r_addr[1:0];

  mem_lane_align u_lane_align (
    .i_width    (bus.ls_width),
    .i_off      (w_off),
    .i_wdata    (bus.ls_wdata),
    .i_rdata    (bus.mem_rdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata_rep),
    .o_rdata    (w_rdata_sh),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_if_rvalid = 1'b0;
    w_ls_rvalid = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_gnt_ls) begin
          w_state_nxt = w_misalign ? RESP : ACCESS;
        end else if (w_gnt_if) begin
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (w_ack || w_expire) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
        w_if_rvalid = (r_owner == OWN_IF);
        w_ls_rvalid = (r_owner == OWN_LS);
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= OWN_IF;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_ls) begin
            r_owner <= OWN_LS;
            r_cnt   <= '0;
            r_addr  <= bus.ls_addr;
            r_we    <= bus.ls_we;
            r_be    <= w_be;
            r_wdata <= w_wdata_rep;
            r_rdata <= '0;
            r_err   <= w_misalign;
          end else if (w_gnt_if) begin
            r_owner <= OWN_IF;
            r_cnt   <= '0;
            r_addr  <= {bus.if_addr[31:2], 2'b00};
            r_we    <= 1'b0;
            r_be    <= 4'b1111;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
          end
        end
        ACCESS: begin
          r_cnt <= w_cnt_inc;
          // An ack on the final allowed cycle wins over the timeout
          if (w_ack) begin
            r_rdata <= r_we ? '0 : w_rdata_sh;
            r_err   <= 1'b0;
          end else if (w_expire) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.if_gnt    = w_gnt_if;
  assign bus.ls_gnt    = w_gnt_ls;
  assign bus.if_rvalid = w_if_rvalid;
  assign bus.ls_rvalid = w_ls_rvalid;
  assign bus.if_rdata  = w_if_rvalid ? r_rdata : '0;
  assign bus.ls_rdata  = w_ls_rvalid ? r_rdata : '0;
  assign bus.if_err    = w_if_rvalid & r_err;
  assign bus.ls_err    = w_ls_rvalid & r_err;

  assign bus.mem_req   = (r_state == ACCESS);
  assign bus.mem_addr  = {r_addr[31:2], 2'b00};
  assign bus.mem_we    = r_we;
  assign bus.mem_be    = r_be;
  assign bus.mem_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ------------------------------------------------------------------
// tb_mem_port_arbiter : random + directed scoreboard bench for the arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int TIMEOUT = 4;
  localparam int TO_W    = 8;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wdata;
    int          delay;
    logic [31:0] rdata;
  } mtx_t;

  typedef struct {
    logic        own_ls;
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        err;
  } resp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  bit   if_pend;
  bit   ls_pend;
`ifdef MEM_ARB_RR_EN
  bit   prio_ls;
`endif
  mtx_t  mq[$];
  resp_t rq[$];

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_if(input logic [31:0] a);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    if_pend     = 1'b1;
  endtask

  task automatic add_ls(input logic we, input logic [1:0] w, input logic [31:0] a,
                        input logic [31:0] d);
    bus.ls_req   = 1'b1;
    bus.ls_we    = we;
    bus.ls_width = w;
    bus.ls_addr  = a;
    bus.ls_wdata = d;
    ls_pend      = 1'b1;
  endtask

  // Predicts the winner and its outcome, then waits for the grant and retires the winner
  task automatic do_round(input int d, input logic [31:0] mword);
    bit    win_ls;
    bit    bad_acc;
    bit    tmo;
    bit    got;
    int    off;
    int    w;
    mtx_t  m;
    resp_t e;
    if (ls_pend && if_pend) begin
`ifdef MEM_ARB_RR_EN
      win_ls = prio_ls;
`else
      win_ls = 1'b1;
`endif
    end else begin
      win_ls = ls_pend;
    end
`ifdef MEM_ARB_RR_EN
    prio_ls = !win_ls;
`endif
    tmo     = (d >= TIMEOUT);
    m.delay = d;
    m.rdata = mword;
    if (win_ls) begin
      off     = int'(bus.ls_addr[1:0]);
      w       = int'(bus.ls_width);
      bad_acc = (w == 0) || (w == 2 && (off % 2) != 0) || (w == 3 && off != 0);
      e.own_ls    = 1'b1;
      e.chk_rdata = 1'b1;
      m.addr      = bus.ls_addr & 32'hFFFF_FFFC;
      m.we        = bus.ls_we;
      m.chk_wdata = bus.ls_we;
      case (w)
        1: begin
          m.be    = 4'(1 << off);
          m.wdata = {24'd0, bus.ls_wdata[7:0]} * 32'h0101_0101;
        end
        2: begin
          m.be    = 4'(3 << off);
          m.wdata = {16'd0, bus.ls_wdata[15:0]} * 32'h0001_0001;
        end
        default: begin
          m.be    = 4'hF;
          m.wdata = bus.ls_wdata;
        end
      endcase
      if (bad_acc) begin
        e.err   = 1'b1;
        e.rdata = 32'd0;
      end else begin
        e.err   = tmo;
        e.rdata = (tmo || bus.ls_we) ? 32'd0 : (mword >> (8 * off));
        mq.push_back(m);
      end
    end else begin
      e.own_ls    = 1'b0;
      e.err       = tmo;
      e.rdata     = mword;
      e.chk_rdata = !tmo;
      m.addr      = bus.if_addr & 32'hFFFF_FFFC;
      m.we        = 1'b0;
      m.be        = 4'hF;
      m.wdata     = 32'd0;
      m.chk_wdata = 1'b0;
      mq.push_back(m);
    end
    rq.push_back(e);

    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      #1;
      if (bus.if_gnt || bus.ls_gnt) begin
        got = 1'b1;
        chk("gnt_ls", 32'(bus.ls_gnt), 32'(win_ls));
        chk("gnt_if", 32'(bus.if_gnt), 32'(!win_ls));
      end else begin
        @(negedge clk);
      end
    end
    if (!got) chk("gnt_wait_expired", 32'd0, 32'd1);
    @(negedge clk);
    if (win_ls) begin
      bus.ls_req = 1'b0;
      ls_pend    = 1'b0;
    end else begin
      bus.if_req = 1'b0;
      if_pend    = 1'b0;
    end
  endtask

  // Memory model: answers each request after its chosen number of wait cycles
  initial begin
    mtx_t cur;
    bit   busy;
    int   waited;
    busy          = 1'b0;
    waited        = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (rst) begin
        busy = 1'b0;
      end else if (bus.mem_req) begin
        if (!busy) begin
          if (mq.size() == 0) begin
            chk("unexpected_mem_req", 32'd1, 32'd0);
          end else begin
            cur    = mq.pop_front();
            busy   = 1'b1;
            waited = 0;
          end
        end
        if (busy) begin
          chk("mem_addr", bus.mem_addr, cur.addr);
          chk("mem_we", 32'(bus.mem_we), 32'(cur.we));
          chk("mem_be", 32'(bus.mem_be), 32'(cur.be));
          if (cur.chk_wdata) chk("mem_wdata", bus.mem_wdata, cur.wdata);
          if (waited == cur.delay) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = cur.rdata;
            busy          = 1'b0;
          end else begin
            waited++;
          end
        end
      end else if (busy) begin
        chk("req_cycles", 32'(waited), 32'(TIMEOUT));
        chk("abort_expected", 32'(cur.delay >= TIMEOUT), 32'd1);
        busy = 1'b0;
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    resp_t e;
    if (bus.if_rvalid || bus.ls_rvalid) begin
      if (bus.if_rvalid && bus.ls_rvalid) chk("dual_rvalid", 32'd1, 32'd0);
      if (rq.size() == 0) begin
        chk("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        e = rq.pop_front();
        chk("rv_owner_ls", 32'(bus.ls_rvalid), 32'(e.own_ls));
        if (e.own_ls) begin
          chk("ls_err", 32'(bus.ls_err), 32'(e.err));
          chk("ls_rdata", bus.ls_rdata, e.rdata);
        end else begin
          chk("if_err", 32'(bus.if_err), 32'(e.err));
          if (e.chk_rdata) chk("if_rdata", bus.if_rdata, e.rdata);
        end
      end
    end
  end

  task automatic drain();
    for (int c = 0; c < 200 && (rq.size() != 0 || mq.size() != 0); c++) @(negedge clk);
    chk("drain_resp", 32'(rq.size()), 32'd0);
    chk("drain_mem", 32'(mq.size()), 32'd0);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    if_pend      = 1'b0;
    ls_pend      = 1'b0;
`ifdef MEM_ARB_RR_EN
    prio_ls      = 1'b1;
`endif
    rst          = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'd0;
    bus.ls_req   = 1'b0;
    bus.ls_addr  = 32'd0;
    bus.ls_we    = 1'b0;
    bus.ls_width = 2'd0;
    bus.ls_wdata = 32'd0;
    repeat (3) @(negedge clk);

    chk("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
    chk("rst_ls_gnt", 32'(bus.ls_gnt), 32'd0);
    chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("rst_ls_rvalid", 32'(bus.ls_rvalid), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_ls_rdata", bus.ls_rdata, 32'd0);
    rst = 1'b0;

    // Directed cases
    add_if(32'h0000_0100);
    do_round(2, 32'hDEAD_BEEF);
    add_ls(1'b1, W_BYTE, 32'h0000_0203, 32'h0000_00A5);
    do_round(1, 32'h0BAD_F00D);
    add_ls(1'b0, W_HALF, 32'h0000_0302, 32'h0);
    do_round(0, 32'h8001_1234);
    add_ls(1'b0, W_WORD, 32'h0000_0401, 32'h0);
    do_round(0, 32'h1111_2222);
    add_ls(1'b0, W_NONE, 32'h0000_0404, 32'h0);
    do_round(0, 32'h3333_4444);
    add_ls(1'b0, W_HALF, 32'h0000_0403, 32'h0);
    do_round(0, 32'h5555_6666);

    // Contention: both requesters held active across four issues
    for (int n = 0; n < 4; n++) begin
      if (!if_pend) add_if(32'h0000_1000 + 32'(n * 4));
      if (!ls_pend) add_ls(1'b0, W_WORD, 32'h0000_2000 + 32'(n * 4), 32'h0);
      do_round(1, $urandom);
    end
    while (if_pend || ls_pend) do_round(0, $urandom);

    // Timeout boundary: ack on the last allowed cycle, then no ack at all
    add_if(32'h0000_0500);
    do_round(TIMEOUT - 1, 32'hCAFE_0001);
    add_if(32'h0000_0504);
    do_round(TIMEOUT + 3, 32'hCAFE_0002);
    add_ls(1'b0, W_BYTE, 32'h0000_0507, 32'h0);
    do_round(TIMEOUT, 32'hCAFE_0003);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      if (!if_pend && $urandom_range(0, 2) != 0) add_if($urandom);
      if (!ls_pend && ($urandom_range(0, 2) != 0 || !if_pend))
        add_ls(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
      do_round(int'($urandom_range(0, TIMEOUT + 2)), $urandom);
    end
    while (if_pend || ls_pend) do_round(0, $urandom);
    drain();

    // Reset while a fetch is waiting on memory
    add_if(32'h0000_0600);
    do_round(TIMEOUT + 5, 32'h1234_5678);
    chk("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_async_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    rq.delete();
    mq.delete();
`ifdef MEM_ARB_RR_EN
    prio_ls = 1'b1;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Arbitration state must be back at its reset value
    add_if(32'h0000_0700);
    add_ls(1'b1, W_HALF, 32'h0000_0702, 32'h0000_BEEF);
    do_round(1, $urandom);
    while (if_pend || ls_pend) do_round(0, $urandom);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired expected finished");
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between the instruction-fetch unit and the load/store unit.
- Arbitrates, runs one outstanding transaction at a time, and generates byte enables and lane-replicated write data from the LSU access width.
- Right-aligns load data to bit 0 so the LSU's sign/zero extension of [7:0]/[15:0] applies directly.
- Detects misaligned or illegal-width LSU accesses and any memory timeout.

Parameters:
- TIMEOUT, 255, max cycles mem_req may wait for mem_ack before abort; 1..2^TO_W-1
- TO_W, 8, width of the timeout counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  32  fetch byte address; bits [1:0] ignored
- if_gnt  out  1  one-cycle pulse: fetch request captured
- if_rvalid  out  1  one-cycle pulse: if_rdata/if_err valid
- if_rdata  out  32  fetched word
- if_err  out  1  fetch aborted by timeout (valid with if_rvalid)
- ls_req  in  1  LSU request; held with ls_* inputs until ls_gnt
- ls_addr  in  32  LSU byte address
- ls_we  in  1  1 = store, 0 = load
- ls_width  in  2  0 illegal, 1 byte, 2 half, 3 word (same encoding as the LSU's mem_write_width)
- ls_wdata  in  32  store data, right-aligned
- ls_gnt  out  1  one-cycle pulse: LSU request captured
- ls_rvalid  out  1  one-cycle pulse: completion (loads and stores)
- ls_rdata  out  32  mem_rdata >> (8*addr[1:0]); 0 for stores/errors
- ls_err  out  1  misaligned, illegal width, or timeout (valid with ls_rvalid)
- mem_req  out  1  memory request; held until mem_ack
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_we  out  1  write enable
- mem_be  out  4  byte enables
- mem_wdata  out  32  byte: {4{d[7:0]}}; half: {2{d[15:0]}}; word: d
- mem_ack  in  1  memory completion; mem_rdata valid same cycle
- mem_rdata  in  32  read word

Behaviour:
- Async reset clears everything: state IDLE, all outputs 0, timeout counter 0, RR pointer to LSU. mem_req drops immediately; the memory tolerates an abandoned request.
- States:
  - IDLE: sample requests.
    - Fixed priority: LSU beats fetch. Winner gets gnt pulse this cycle; its request is registered.
    - LSU request with error (width 0; half with addr[0]=1; word with addr[1:0]!=0): go to RESP, no memory access.
    - Otherwise go to ACCESS.
  - ACCESS: mem_req=1, registered mem_* stable, counter increments each cycle.
    - mem_ack: capture rdata, go to RESP.
    - Counter reaching TIMEOUT without ack: deassert mem_req, set err, go to RESP.
  - RESP: owner's rvalid=1 for exactly one cycle with rdata/err; then IDLE.
- Latency: gnt at cycle 0; mem_req from cycle 1; rvalid the cycle after the mem_ack cycle. Errored LSU requests get rvalid at cycle 1. Minimum back-to-back issue is every 3 cycles; no new gnt in ACCESS or RESP.
- mem_ack outside ACCESS is ignored. An ack in the same cycle the counter hits TIMEOUT counts as success.
- mem_be:
  - byte: 0001 << addr[1:0]
  - half: 0011 << addr[1:0]
  - word: 1111
  - fetch: mem_we=0, mem_be=1111
- Loads: mem_we=0, mem_be per width. ls_rdata is the unmasked shifted word; the LSU extends it.
- Requests dropped before gnt are a protocol violation; inputs are sampled only in IDLE.
- Counter is cleared on entry to ACCESS.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration. When both requesters are active in IDLE, the requester not granted last wins. The 1-bit pointer updates on every gnt. A single requester always wins.
- Undefined: fixed LSU priority, no pointer register.

Decomposition:
- Shared package holds:
  - width encodings W_NONE=0, W_BYTE=1, W_HALF=2, W_WORD=3
  - state enum IDLE/ACCESS/RESP
  - owner enum OWN_IF/OWN_LS
- One natural sub-module: mem_lane_align. Purely combinational: width, addr[1:0], wdata, rdata → mem_be, replicated wdata, shifted rdata, misalign flag.

Test Plan:
- Fetch at 0x100, ack after 2 wait cycles with 0xDEADBEEF → if_gnt cycle 0; mem_addr=0x100, be=1111 from cycle 1; if_rvalid with 0xDEADBEEF, if_err=0.
- Store byte 0xA5 at 0x203 → mem_addr=0x200, be=1000, wdata=0xA5A5A5A5, we=1; ls_rvalid with ls_err=0.
- Load half at 0x302, mem_rdata=0x8001_1234 → be=1100, ls_rdata=0x0000_8001.
- Load word at 0x401 → ls_gnt then ls_rvalid next cycle with ls_err=1; mem_req never asserted.
- Both requesters active for 4 issues → without macro all grants go to LSU; with MEM_ARB_RR_EN grants go LSU, IF, LSU, IF.
- TIMEOUT=4, no ack → mem_req high 4 cycles then low, rvalid+err=1. Reset asserted mid-ACCESS → mem_req=0 asynchronously, state IDLE, no rvalid.
